mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in EX, directly downstream of the GPR read ports: operands are the forwarded RD1/RD2 values.
- Models fixed MIPS mult/div latency with a busy flag that the hazard unit uses to stall mfhi/mflo and new MDU ops.
- Results are computed at issue, held internally and committed to HI/LO when the latency expires.

Parameters:
- MUL_LAT, 5, cycles busy for MULT/MULTU (must be >= 1)
- DIV_LAT, 10, cycles busy for DIV/DIVU (must be >= 1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  issue strobe, sampled at the rising edge
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved, no effect
- a  input  32  rs operand (forwarded RD1)
- b  input  32  rt operand (forwarded RD2)
- busy  output  1  multi-cycle op in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset, asynchronous at any time including mid-operation: hi=0, lo=0, busy=0, counter=0, pending result discarded. No commit occurs after reset is released.
- States:
  - IDLE (busy=0)
  - RUN (busy=1, counter = remaining cycles)
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}:
  - Latch the op result into res_hi/res_lo at that edge.
  - Load counter=MUL_LAT or DIV_LAT; go to RUN.
- RUN, each edge:
  - counter decrements.
  - At the edge where counter==1: hi<=res_hi, lo<=res_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly LAT cycles. New HI/LO are visible in the first cycle with busy=0.
- MTHI/MTLO in IDLE with start=1: hi<=a (or lo<=a) at that edge; busy stays 0; no other register is touched.
- start while busy=1: ignored completely, including MTHI/MTLO. The hazard unit must stall on (busy | start) for any MDU op, mfhi or mflo.
- Reserved op with start=1: no state change.
- Arithmetic:
  - MULT: {hi,lo} = signed a × signed b, 64-bit.
  - MULTU: {hi,lo} = unsigned a × unsigned b, 64-bit.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend a.
  - DIVU: unsigned quotient in lo, unsigned remainder in hi.
- Divide corner cases:
  - b==0 (DIV or DIVU): unit still goes busy for DIV_LAT cycles, but hi/lo are left unchanged at commit.
  - DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Back-to-back: start may be accepted in the same cycle that busy returns to 0.
- hi/lo are plain register outputs with no bypass. During RUN they keep their old values.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT..MDU_MTLO.
  - MUL_LAT_DEF and DIV_LAT_DEF constants.
  - The decoder and hazard unit import the same encodings.
- One sub-module, mdu_core: combinational signed/unsigned multiply and divide producing the 64-bit {res_hi,res_lo}, including the divide-by-zero "no-write" flag.
- mdu_hilo owns the counter, state and HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, start one cycle:
  - busy=1 for exactly 5 cycles, hi/lo held during RUN.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Repeat with MULTU: hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2:
  - busy=1 for 10 cycles.
  - Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - Repeat with DIVU a=7, b=2: lo=3, hi=1.
- Divide by zero: preload with MTHI 0x1234, MTLO 0x5678, then DIV a=5, b=0:
  - busy for 10 cycles.
  - hi=0x1234, lo=0x5678 unchanged.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue while busy: start MULT 2×3, then on cycle 2 assert start MTLO a=0xDEAD and start DIV.
  - Both are ignored.
  - Final lo=6, hi=0, busy drops after exactly 5 cycles.
- Reset mid-operation: start DIV 100/7, assert reset at cycle 4.
  - busy=0 and hi=lo=0 immediately, asynchronously.
  - Still hi=lo=0 after 20 further cycles.
  - Then MTHI a=0xCAFE gives hi=0xCAFE after one edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state constants used by the MDU, decoder and hazard unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // MULT, MULTU, DIV and DIVU occupy the low half of the encoding space.
    function automatic logic is_multi(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath: 64-bit signed/unsigned product or quotient/remainder
// pair, plus a flag that suppresses the HI/LO write on divide by zero.
module mdu_core
    import mdu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        no_write_o
);

    logic        mul_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign mul_signed = (op_i == MDU_MULT);
    assign a_ext      = mul_signed ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    assign b_ext      = mul_signed ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    // The low 64 bits of a sign-extended product equal the signed product.
    assign prod       = a_ext * b_ext;

    assign a_neg   = (op_i == MDU_DIV) && a_i[31];
    assign b_neg   = (op_i == MDU_DIV) && b_i[31];
    assign a_mag   = a_neg ? (~a_i + 32'd1) : a_i;
    assign b_mag   = b_neg ? (~b_i + 32'd1) : b_i;
    // Divisor of zero is replaced so the datapath stays defined; the result is discarded.
    assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

    assign res_hi_o   = is_div(op_i) ? rem  : prod[63:32];
    assign res_lo_o   = is_div(op_i) ? quot : prod[31:0];
    assign no_write_o = is_div(op_i) && (b_i == 32'd0);

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MIPS multiply/divide unit: result computed at issue, committed
// to the architectural HI/LO registers after a fixed latency; busy exposes the FSM state.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [15:0] MUL_CNT = 16'(MUL_LAT);
    localparam logic [15:0] DIV_CNT = 16'(DIV_LAT);

    logic        state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        skip_q, skip_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] core_hi;
    logic [31:0] core_lo;
    logic        core_no_write;

    mdu_core u_core (
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .res_hi_o   (core_hi),
        .res_lo_o   (core_lo),
        .no_write_o (core_no_write)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        skip_d   = skip_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == ST_IDLE) begin
            if (start && is_multi(op)) begin
                res_hi_d = core_hi;
                res_lo_d = core_lo;
                skip_d   = core_no_write;
                cnt_d    = is_div(op) ? DIV_CNT : MUL_CNT;
                state_d  = ST_RUN;
            end else if (start && (op == MDU_MTHI)) begin
                hi_d = a;
            end else if (start && (op == MDU_MTLO)) begin
                lo_d = a;
            end
        end else begin
            // Any start while running is dropped; the hazard unit stalls the issuer.
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
                if (!skip_q) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            skip_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            skip_q   <= skip_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: driver pushes expected {latency, hi, lo} per
// multi-cycle op, monitor pops and compares when busy falls.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    logic [79:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_hilo #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    int          busy_cnt = 0;
    logic        prev_busy = 1'b0;
    logic [79:0] e;

    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL commit: unexpected commit hi=%h lo=%h, expected none", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 64'(busy_cnt), 64'(e[79:64]));
                    check("hilo", {hi, lo}, e[63:0]);
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    // driver tasks (called at a negedge, return at the following negedge)
    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] eh, input logic [31:0] el);
        int   n;
        logic held_bad;
        n        = 0;
        held_bad = 1'b0;
        while (busy && n < 100) begin
            if (hi !== m_hi || lo !== m_lo) held_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check("busy_timeout", 64'(busy), 64'd0);
        check("held_during_run", 64'(held_bad), 64'd0);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [15:0] lat, input logic [31:0] eh, input logic [31:0] el);
        exp_q.push_back({lat, eh, el});
        start_op(o, x, y);
        wait_done(eh, el);
    endtask

    task automatic move_op(input logic [2:0] o, input logic [31:0] x);
        start_op(o, x, 32'd0);
        if (o == MDU_MTHI) m_hi = x;
        if (o == MDU_MTLO) m_lo = x;
        check("move_busy", 64'(busy), 64'd0);
        check("move_hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_state", {31'd0, busy, hi, lo}, 96'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("post_reset", {31'd0, busy, hi, lo}, 96'd0);

        // multiplies, back to back
        run_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3,        16'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3,        16'd5,  32'h0000_0002, 32'hFFFF_FFFA);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 16'd5, 32'h4000_0000, 32'h0000_0000);

        // divides
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,        16'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(MDU_DIVU,  32'd7,         32'd2,        16'd10, 32'h0000_0001, 32'h0000_0003);
        run_op(MDU_DIV,   32'd7,         32'hFFFF_FFFE, 16'd10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op(MDU_DIVU,  32'hFFFF_FFFF, 32'd16,       16'd10, 32'h0000_000F, 32'h0FFF_FFFF);

        // divide by zero leaves HI/LO untouched
        move_op(MDU_MTHI, 32'h0000_1234);
        move_op(MDU_MTLO, 32'h0000_5678);
        run_op(MDU_DIV,   32'd5,         32'd0,        16'd10, 32'h0000_1234, 32'h0000_5678);

        // signed overflow
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 16'd10, 32'h0000_0000, 32'h8000_0000);

        // reserved ops
        start_op(3'd6, 32'h1111_1111, 32'h2222_2222);
        start_op(3'd7, 32'h3333_3333, 32'h4444_4444);
        check("reserved_busy", 64'(busy), 64'd0);
        check("reserved_hilo", {hi, lo}, {m_hi, m_lo});

        // starts during busy are ignored
        exp_q.push_back({16'd5, 32'd0, 32'd6});
        start_op(MDU_MULT, 32'd2, 32'd3);
        start_op(MDU_MTLO, 32'h0000_DEAD, 32'd0);
        start_op(MDU_DIV,  32'd100, 32'd7);
        wait_done(32'd0, 32'd6);
        @(negedge clk);
        check("ignored_idle", {31'd0, busy, hi, lo}, {31'd0, 1'b0, 32'd0, 32'd6});

        // asynchronous reset mid-divide
        start_op(MDU_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {31'd0, busy, hi, lo}, 96'd0);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (20) @(negedge clk);
        check("no_commit_after_reset", {31'd0, busy, hi, lo}, 96'd0);
        move_op(MDU_MTHI, 32'h0000_CAFE);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
